unidade_de_busca: RTL and testbench

Instruction-fetch stage of the processor, directly upstream of the instruction memory. It owns the program counter and drives the memory's word address. It latches the returned word into an instruction register for the control unit. It also handles sequential advance, taken jumps and branches, datapath stalls, halt and out-of-range fetches.

---
 rtl/unidade_de_busca_pkg.sv | 43 ++++
 rtl/unidade_de_busca_if.sv | 35 +++
 rtl/unidade_de_busca.sv | 91 +++++++++
 tb/tb_unidade_de_busca.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/unidade_de_busca_pkg.sv
// Shared processor definitions: opcodes, instruction field layout and the
// fetch-stage state encoding.
package unidade_de_busca_pkg;

  localparam int LARGURA          = 32;
  localparam int ENDERECO_INICIAL = 1;
  localparam int ULTIMO_ENDERECO  = 130;

  // Instruction field layout
  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 27;
  localparam int OPCODE_BITS  = 5;
  localparam int REG_BITS     = 5;
  localparam int IMM_MOVE     = 22;
  localparam int IMM_BRANCH   = 17;
  localparam int IMM_JUMP     = 27;

  // Opcodes
  localparam logic [OPCODE_BITS-1:0] OP_ADD    = 5'd1;
  localparam logic [OPCODE_BITS-1:0] OP_BRANCH = 5'd12;
  localparam logic [OPCODE_BITS-1:0] OP_JUMP   = 5'd16;
  localparam logic [OPCODE_BITS-1:0] OP_HALT   = 5'd18;
  localparam logic [OPCODE_BITS-1:0] OP_IN     = 5'd19;
  localparam logic [OPCODE_BITS-1:0] OP_OUT    = 5'd20;
  localparam logic [OPCODE_BITS-1:0] OP_MOVE   = 5'd22;
  localparam logic [OPCODE_BITS-1:0] OP_LOAD   = 5'd23;
  localparam logic [OPCODE_BITS-1:0] OP_STORE  = 5'd24;
  localparam logic [OPCODE_BITS-1:0] OP_LOADI  = 5'd25;
  localparam logic [OPCODE_BITS-1:0] OP_CMP    = 5'd30;

  // Fetch-stage FSM encoding
  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_busca_t;

  // Extracts the opcode field of an instruction word
  function automatic logic [OPCODE_BITS-1:0] opcode_de(input logic [LARGURA-1:0] palavra);
    return palavra[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/unidade_de_busca_if.sv
// Bundle between the fetch stage, the instruction memory and the control unit.
//
// Handshake: there is no ready back-pressure on the instruction register.
// valida=1 means instrucaoAtual/pcAtual hold an instruction to execute in this
// cycle. pausa=1 freezes the whole stage (PC, IR, pcAtual, valida) and
// overrides desvio, so control must re-assert a redirect after a stall.
// The memory answers combinationally: instrucao corresponds to endereco in
// the same cycle.
interface unidade_de_busca_if;
  import unidade_de_busca_pkg::*;

  logic [LARGURA-1:0] instrucao;
  logic [LARGURA-1:0] endereco;
  logic               pausa;
  logic               desvio;
  logic [LARGURA-1:0] alvo;
  logic [LARGURA-1:0] instrucaoAtual;
  logic [LARGURA-1:0] pcAtual;
  logic               valida;
  logic               parado;
  logic               erro;
  estado_busca_t      estado;   // debug view of the fetch FSM

  // Fetch stage side
  modport master (
    input  instrucao, pausa, desvio, alvo,
    output endereco, instrucaoAtual, pcAtual, valida, parado, erro, estado
  );

  // Memory/control side
  modport slave (
    output instrucao, pausa, desvio, alvo,
    input  endereco, instrucaoAtual, pcAtual, valida, parado, erro, estado
  );
endinterface

// File: rtl/unidade_de_busca.sv
// Instruction fetch stage: owns the PC, drives the memory address, latches the
// returned word into the instruction register, and handles jumps, stalls,
// halt and out-of-range fetches.
module unidade_de_busca
  import unidade_de_busca_pkg::*;
#(
  parameter int P_ENDERECO_INICIAL = ENDERECO_INICIAL,
  parameter int P_ULTIMO_ENDERECO  = ULTIMO_ENDERECO
) (
  input  logic                clock,
  input  logic                reset,
  unidade_de_busca_if.master  bus
);

  logic [LARGURA-1:0] r_pc;
  logic [LARGURA-1:0] r_ir;
  logic [LARGURA-1:0] r_pc_atual;
  logic               r_valida;
  logic               r_parado;
  logic               r_erro;
  estado_busca_t      r_estado;

  logic [LARGURA-1:0] w_pc_prox;
  logic               w_fora;
  logic               w_halt;

  localparam logic [LARGURA-1:0] L_PC_RESET = LARGURA'(P_ENDERECO_INICIAL);
  localparam logic [LARGURA-1:0] L_PC_MAX   = LARGURA'(P_ULTIMO_ENDERECO);

  // Incrementer, range comparator and halt decode on the word being fetched
  assign w_pc_prox = r_pc + LARGURA'(1);
  assign w_fora    = (r_pc > L_PC_MAX);
  assign w_halt    = (opcode_de(bus.instrucao) == OP_HALT);

  // Fetch FSM; all outputs are registered. In BUSCA the if-chain order is the
  // priority: stall, redirect, out-of-range, halt, sequential fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= L_PC_RESET;
      r_ir       <= '0;
      r_pc_atual <= '0;
      r_valida   <= 1'b0;
      r_parado   <= 1'b0;
      r_erro     <= 1'b0;
      r_estado   <= INICIO;
    end else begin
      case (r_estado)
        // Memory initialises on its first edge; nothing to latch yet
        INICIO: r_estado <= BUSCA;
        BUSCA: begin
          if (bus.pausa) begin
            r_estado <= BUSCA;
          end else if (bus.desvio) begin
            // Sequential word fetched this cycle is discarded: one bubble
            r_pc     <= bus.alvo;
            r_valida <= 1'b0;
          end else if (w_fora) begin
            r_estado <= PARADO;
            r_parado <= 1'b1;
            r_erro   <= 1'b1;
            r_valida <= 1'b0;
          end else if (w_halt) begin
            // Halt word is issued once; PC stays on it
            r_ir       <= bus.instrucao;
            r_pc_atual <= r_pc;
            r_valida   <= 1'b1;
            r_parado   <= 1'b1;
            r_estado   <= PARADO;
          end else begin
            r_ir       <= bus.instrucao;
            r_pc_atual <= r_pc;
            r_valida   <= 1'b1;
            r_pc       <= w_pc_prox;
          end
        end
        // Terminal until reset; only valida drops
        PARADO: r_valida <= 1'b0;
        default: r_estado <= INICIO;
      endcase
    end
  end

  assign bus.endereco       = r_pc;
  assign bus.instrucaoAtual = r_ir;
  assign bus.pcAtual        = r_pc_atual;
  assign bus.valida         = r_valida;
  assign bus.parado         = r_parado;
  assign bus.erro           = r_erro;
  assign bus.estado         = r_estado;

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench for the fetch stage with a combinational instruction memory.
module tb_unidade_de_busca;
  import unidade_de_busca_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem [0:255];
  logic [31:0] halt_word;

  unidade_de_busca_if bus();

  unidade_de_busca dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // Clock and combinational memory
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.instrucao = (bus.endereco < 32'd256) ? mem[bus.endereco[7:0]] : 32'hFFFF_FFFF;

  // Memory image: OP_ADD with the address in the low bits, distinct per word
  task automatic load_mem();
    for (int a = 0; a < 256; a++) mem[a] = {OP_ADD, 27'(a)};
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Two reset edges, then release; returns just after E1 (state BUSCA)
  task automatic restart();
    @(negedge clock);
    reset = 1'b1; bus.pausa = 1'b0; bus.desvio = 1'b0; bus.alvo = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  // Advance until the IR holds the word from address pc, bounded
  task automatic run_to_pc(input logic [31:0] pc);
    int n;
    n = 0;
    while (!(bus.valida === 1'b1 && bus.pcAtual === pc) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL run_to_pc timeout: pcAtual=%0d required=%0d", bus.pcAtual, pc);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; bus.pausa = 1'b0; bus.desvio = 1'b0; bus.alvo = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.endereco !== 32'd1) begin errors++; $display("FAIL reset_endereco got=%0d exp=1", bus.endereco); end
      checks++; if (bus.valida !== 1'b0 || bus.parado !== 1'b0 || bus.erro !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b%b exp=000", bus.valida, bus.parado, bus.erro); end
      checks++; if (bus.instrucaoAtual !== 32'd0 || bus.pcAtual !== 32'd0) begin errors++; $display("FAIL reset_ir got=%h/%0d exp=0/0", bus.instrucaoAtual, bus.pcAtual); end
      checks++; if (bus.estado !== INICIO) begin errors++; $display("FAIL reset_estado got=%0d exp=%0d", bus.estado, INICIO); end
    end
    reset = 1'b0;
    step();  // after E1
    checks++; if (bus.estado !== BUSCA || bus.valida !== 1'b0 || bus.endereco !== 32'd1) begin errors++; $display("FAIL inicio_cycle estado=%0d valida=%b end=%0d exp=1/0/1", bus.estado, bus.valida, bus.endereco); end
    for (int k = 1; k <= 3; k++) begin
      step();  // after E2, E3, E4
      checks++; if (bus.valida !== 1'b1 || bus.pcAtual !== 32'(k)) begin errors++; $display("FAIL seq_fetch valida=%b pcAtual=%0d exp=1/%0d", bus.valida, bus.pcAtual, k); end
      checks++; if (bus.instrucaoAtual !== {OP_ADD, 27'(k)} || bus.endereco !== 32'(k + 1)) begin errors++; $display("FAIL seq_ir ir=%h end=%0d exp=%h/%0d", bus.instrucaoAtual, bus.endereco, {OP_ADD, 27'(k)}, k + 1); end
    end
  endtask

  task automatic test_jump();
    restart();
    run_to_pc(32'd20);
    bus.desvio = 1'b1; bus.alvo = 32'd30;
    step();
    bus.desvio = 1'b0;
    checks++; if (bus.valida !== 1'b0 || bus.endereco !== 32'd30) begin errors++; $display("FAIL jump_bubble valida=%b end=%0d exp=0/30", bus.valida, bus.endereco); end
    checks++; if (bus.pcAtual !== 32'd20 || bus.instrucaoAtual !== {OP_ADD, 27'd20}) begin errors++; $display("FAIL jump_hold pcAtual=%0d ir=%h exp=20/%h", bus.pcAtual, bus.instrucaoAtual, {OP_ADD, 27'd20}); end
    step();
    checks++; if (bus.valida !== 1'b1 || bus.pcAtual !== 32'd30 || bus.instrucaoAtual !== {OP_ADD, 27'd30}) begin errors++; $display("FAIL jump_target valida=%b pcAtual=%0d ir=%h exp=1/30/%h", bus.valida, bus.pcAtual, bus.instrucaoAtual, {OP_ADD, 27'd30}); end
    step();
    checks++; if (bus.pcAtual !== 32'd31) begin errors++; $display("FAIL jump_after pcAtual=%0d exp=31", bus.pcAtual); end
  endtask

  task automatic test_pausa();
    restart();
    run_to_pc(32'd10);
    bus.pausa = 1'b1; bus.desvio = 1'b1; bus.alvo = 32'd77;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.pcAtual !== 32'd10 || bus.instrucaoAtual !== {OP_ADD, 27'd10}) begin errors++; $display("FAIL pausa_ir pcAtual=%0d ir=%h exp=10/%h", bus.pcAtual, bus.instrucaoAtual, {OP_ADD, 27'd10}); end
      checks++; if (bus.endereco !== 32'd11 || bus.valida !== 1'b1) begin errors++; $display("FAIL pausa_pc end=%0d valida=%b exp=11/1", bus.endereco, bus.valida); end
    end
    bus.pausa = 1'b0; bus.desvio = 1'b0;
    step();
    checks++; if (bus.pcAtual !== 32'd11 || bus.endereco !== 32'd12) begin errors++; $display("FAIL pausa_resume pcAtual=%0d end=%0d exp=11/12", bus.pcAtual, bus.endereco); end
  endtask

  task automatic test_halt();
    mem[49] = halt_word;
    restart();
    run_to_pc(32'd48);
    step();
    checks++; if (bus.pcAtual !== 32'd49 || bus.valida !== 1'b1 || bus.instrucaoAtual !== halt_word) begin errors++; $display("FAIL halt_issue pcAtual=%0d valida=%b ir=%h exp=49/1/%h", bus.pcAtual, bus.valida, bus.instrucaoAtual, halt_word); end
    checks++; if (bus.parado !== 1'b1 || bus.endereco !== 32'd49) begin errors++; $display("FAIL halt_parado parado=%b end=%0d exp=1/49", bus.parado, bus.endereco); end
    bus.desvio = 1'b1; bus.alvo = 32'd5;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (bus.valida !== 1'b0 || bus.parado !== 1'b1 || bus.erro !== 1'b0) begin errors++; $display("FAIL halt_flags valida=%b parado=%b erro=%b exp=0/1/0", bus.valida, bus.parado, bus.erro); end
      checks++; if (bus.endereco !== 32'd49 || bus.pcAtual !== 32'd49) begin errors++; $display("FAIL halt_hold end=%0d pcAtual=%0d exp=49/49", bus.endereco, bus.pcAtual); end
    end
    bus.desvio = 1'b0;
    mem[49] = {OP_ADD, 27'd49};
  endtask

  task automatic test_out_of_range();
    // Last valid address 130 still fetches; 131 raises the error
    restart();
    run_to_pc(32'd3);
    bus.desvio = 1'b1; bus.alvo = 32'd129;
    step();
    bus.desvio = 1'b0;
    step();
    step();
    checks++; if (bus.pcAtual !== 32'd130 || bus.valida !== 1'b1 || bus.endereco !== 32'd131 || bus.erro !== 1'b0) begin errors++; $display("FAIL last_addr pcAtual=%0d valida=%b end=%0d erro=%b exp=130/1/131/0", bus.pcAtual, bus.valida, bus.endereco, bus.erro); end
    step();
    checks++; if (bus.parado !== 1'b1 || bus.erro !== 1'b1 || bus.valida !== 1'b0) begin errors++; $display("FAIL oor_seq parado=%b erro=%b valida=%b exp=1/1/0", bus.parado, bus.erro, bus.valida); end
    // Redirect beyond the range
    restart();
    run_to_pc(32'd5);
    bus.desvio = 1'b1; bus.alvo = 32'd131;
    step();
    bus.desvio = 1'b0;
    checks++; if (bus.parado !== 1'b0 || bus.valida !== 1'b0 || bus.endereco !== 32'd131) begin errors++; $display("FAIL oor_accept parado=%b valida=%b end=%0d exp=0/0/131", bus.parado, bus.valida, bus.endereco); end
    step();
    checks++; if (bus.parado !== 1'b1 || bus.erro !== 1'b1 || bus.valida !== 1'b0) begin errors++; $display("FAIL oor_jump parado=%b erro=%b valida=%b exp=1/1/0", bus.parado, bus.erro, bus.valida); end
    checks++; if (bus.pcAtual !== 32'd5 || bus.instrucaoAtual !== {OP_ADD, 27'd5}) begin errors++; $display("FAIL oor_ir pcAtual=%0d ir=%h exp=5/%h", bus.pcAtual, bus.instrucaoAtual, {OP_ADD, 27'd5}); end
    reset = 1'b1;
    step();
    checks++; if (bus.parado !== 1'b0 || bus.erro !== 1'b0 || bus.valida !== 1'b0 || bus.endereco !== 32'd1) begin errors++; $display("FAIL oor_reset parado=%b erro=%b valida=%b end=%0d exp=0/0/0/1", bus.parado, bus.erro, bus.valida, bus.endereco); end
    reset = 1'b0;
    step();
    step();
    checks++; if (bus.pcAtual !== 32'd1 || bus.valida !== 1'b1) begin errors++; $display("FAIL oor_restart pcAtual=%0d valida=%b exp=1/1", bus.pcAtual, bus.valida); end
  endtask

  task automatic test_reset_mid();
    restart();
    run_to_pc(32'd15);
    bus.pausa = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++; if (bus.endereco !== 32'd1 || bus.valida !== 1'b0 || bus.instrucaoAtual !== 32'd0 || bus.pcAtual !== 32'd0) begin errors++; $display("FAIL mid_reset end=%0d valida=%b ir=%h pcAtual=%0d exp=1/0/0/0", bus.endereco, bus.valida, bus.instrucaoAtual, bus.pcAtual); end
    checks++; if (bus.estado !== INICIO) begin errors++; $display("FAIL mid_reset_estado got=%0d exp=%0d", bus.estado, INICIO); end
    reset = 1'b0; bus.pausa = 1'b0;
    step();
    checks++; if (bus.estado !== BUSCA || bus.valida !== 1'b0) begin errors++; $display("FAIL mid_inicio estado=%0d valida=%b exp=%0d/0", bus.estado, bus.valida, BUSCA); end
    step();
    checks++; if (bus.pcAtual !== 32'd1 || bus.valida !== 1'b1) begin errors++; $display("FAIL mid_restart pcAtual=%0d valida=%b exp=1/1", bus.pcAtual, bus.valida); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    halt_word = {OP_HALT, 27'd0};
    reset = 1'b1;
    bus.pausa = 1'b0;
    bus.desvio = 1'b0;
    bus.alvo = '0;
    load_mem();
    test_reset();
    test_jump();
    test_pausa();
    test_halt();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
